// File: rtl/src_ctrl_pkg.sv
// Shared opcodes, FSM states, instruction classes and the control-line bundle for the Mini-SRC sequencer.
package src_ctrl_pkg;

  localparam int unsigned IR_W  = 32;
  localparam int unsigned OP_W  = 5;
  localparam int unsigned CNT_W = 32;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  localparam logic [OP_W-1:0] ALU_OP_ADD = 5'b00011;
  localparam logic [OP_W-1:0] ALU_OP_AND = 5'b00101;
  localparam logic [OP_W-1:0] ALU_OP_OR  = 5'b00110;

  typedef enum logic [3:0] {
    ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    CLS_RTYPE, CLS_IMM, CLS_MULDIV, CLS_UNARY, CLS_MOVHL,
    CLS_LD, CLS_LDI, CLS_ST, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } instr_class_e;

  typedef struct packed {
    logic            gra;
    logic            grb;
    logic            grc;
    logic            rin;
    logic            rout;
    logic            baout;
    logic            pcout;
    logic            pcin;
    logic            incpc;
    logic            marin;
    logic            mdrin;
    logic            mdrout;
    logic            read;
    logic            write;
    logic            irin;
    logic            yin;
    logic            zin;
    logic            zlowout;
    logic            zhighout;
    logic            hiin;
    logic            loin;
    logic            hiout;
    logic            loout;
    logic            cout;
    logic [OP_W-1:0] alu_op;
    logic            illegal;
  } ctrl_t;

  // Immediate forms reuse the register-form ALU codes.
  function automatic logic [OP_W-1:0] imm_alu_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ANDI: return ALU_OP_AND;
      OP_ORI:  return ALU_OP_OR;
      default: return ALU_OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_decode.sv
// Combinational opcode to instruction-class decode for the Mini-SRC control sequencer.
module ctrl_decode
  import src_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] opcode_i,
  output instr_class_e    cls_c_o
);

  always_comb begin
    cls_c_o = CLS_ILLEGAL;
    if (opcode_i >= OP_ADD && opcode_i <= OP_SHL) begin
      cls_c_o = CLS_RTYPE;
    end else begin
      case (opcode_i)
        OP_LD:                   cls_c_o = CLS_LD;
        OP_LDI:                  cls_c_o = CLS_LDI;
        OP_ST:                   cls_c_o = CLS_ST;
        OP_ADDI, OP_ANDI, OP_ORI: cls_c_o = CLS_IMM;
        OP_MUL, OP_DIV:          cls_c_o = CLS_MULDIV;
        OP_NEG, OP_NOT:          cls_c_o = CLS_UNARY;
        OP_MFHI, OP_MFLO:        cls_c_o = CLS_MOVHL;
        OP_NOP:                  cls_c_o = CLS_NOP;
        OP_HALT:                 cls_c_o = CLS_HALT;
        default:                 cls_c_o = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hard-wired Mini-SRC control unit: T-state sequencer with Moore control decode and memory stall.
// Optional instruction counter output enabled by defining CTRL_INSTR_CNT_EN.
module control_sequencer
  import src_ctrl_pkg::*;
#(
  parameter bit              MEM_HANDSHAKE = 1'b1,
  parameter logic [OP_W-1:0] ALU_ADD       = ALU_OP_ADD
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [IR_W-1:0] ir,
  input  logic            mem_ready,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            Read,
  output logic            Write,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            HIin,
  output logic            LOin,
  output logic            HIout,
  output logic            LOout,
  output logic            Cout,
  output logic [OP_W-1:0] alu_op,
  output logic            run,
  output logic            illegal
`ifdef CTRL_INSTR_CNT_EN
  ,
  output logic [CNT_W-1:0] instr_count
`endif
);

  state_e          state_q, state_d;
  instr_class_e    cls_c;
  ctrl_t           ctrl_c, ctrl_out_c;
  logic [OP_W-1:0] opcode;
  logic            mem_done;
  logic            unused_ir_bits;

  assign opcode         = ir[IR_W-1 -: OP_W];
  assign unused_ir_bits = ^ir[IR_W-OP_W-1:0];
  assign mem_done       = !MEM_HANDSHAKE || mem_ready;

  ctrl_decode u_decode (
    .opcode_i (opcode),
    .cls_c_o  (cls_c)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_q <= ST_T0;
    else       state_q <= state_d;
  end

  // Next-state and per-state control decode; the opcode is only consulted from T3 onward.
  always_comb begin
    state_d = state_q;
    ctrl_c  = '0;
    case (state_q)
      ST_T0: begin
        ctrl_c.pcout = 1'b1; ctrl_c.marin = 1'b1; ctrl_c.incpc = 1'b1; ctrl_c.zin = 1'b1;
        state_d = ST_T1;
      end
      ST_T1: begin
        ctrl_c.zlowout = 1'b1; ctrl_c.pcin = 1'b1; ctrl_c.read = 1'b1; ctrl_c.mdrin = 1'b1;
        if (mem_done) state_d = ST_T2;
      end
      ST_T2: begin
        ctrl_c.mdrout = 1'b1; ctrl_c.irin = 1'b1;
        state_d = ST_T3;
      end
      ST_T3: begin
        state_d = ST_T4;
        case (cls_c)
          CLS_RTYPE, CLS_IMM: begin
            ctrl_c.grb = 1'b1; ctrl_c.rout = 1'b1; ctrl_c.yin = 1'b1;
          end
          CLS_MULDIV: begin
            ctrl_c.gra = 1'b1; ctrl_c.rout = 1'b1; ctrl_c.yin = 1'b1;
          end
          CLS_UNARY: begin
            ctrl_c.grb = 1'b1; ctrl_c.rout = 1'b1; ctrl_c.zin = 1'b1; ctrl_c.alu_op = opcode;
          end
          CLS_MOVHL: begin
            ctrl_c.hiout = (opcode == OP_MFHI);
            ctrl_c.loout = (opcode != OP_MFHI);
            ctrl_c.gra   = 1'b1; ctrl_c.rin = 1'b1;
            state_d      = ST_T0;
          end
          CLS_LD, CLS_LDI, CLS_ST: begin
            ctrl_c.grb = 1'b1; ctrl_c.baout = 1'b1; ctrl_c.yin = 1'b1;
          end
          CLS_HALT: state_d = ST_HALT;
          CLS_NOP:  state_d = ST_T0;
          default: begin
            ctrl_c.illegal = 1'b1;
            state_d        = ST_T0;
          end
        endcase
      end
      ST_T4: begin
        state_d = ST_T5;
        case (cls_c)
          CLS_RTYPE: begin
            ctrl_c.grc = 1'b1; ctrl_c.rout = 1'b1; ctrl_c.zin = 1'b1; ctrl_c.alu_op = opcode;
          end
          CLS_IMM: begin
            ctrl_c.cout = 1'b1; ctrl_c.zin = 1'b1; ctrl_c.alu_op = imm_alu_op(opcode);
          end
          CLS_MULDIV: begin
            ctrl_c.grb = 1'b1; ctrl_c.rout = 1'b1; ctrl_c.zin = 1'b1; ctrl_c.alu_op = opcode;
          end
          CLS_UNARY: begin
            ctrl_c.zlowout = 1'b1; ctrl_c.gra = 1'b1; ctrl_c.rin = 1'b1;
            state_d        = ST_T0;
          end
          default: begin
            ctrl_c.cout = 1'b1; ctrl_c.zin = 1'b1; ctrl_c.alu_op = ALU_ADD;
          end
        endcase
      end
      ST_T5: begin
        ctrl_c.zlowout = 1'b1;
        case (cls_c)
          CLS_MULDIV: begin
            ctrl_c.loin = 1'b1;
            state_d     = ST_T6;
          end
          CLS_LD, CLS_ST: begin
            ctrl_c.marin = 1'b1;
            state_d      = ST_T6;
          end
          default: begin
            ctrl_c.gra = 1'b1; ctrl_c.rin = 1'b1;
            state_d    = ST_T0;
          end
        endcase
      end
      ST_T6: begin
        case (cls_c)
          CLS_MULDIV: begin
            ctrl_c.zhighout = 1'b1; ctrl_c.hiin = 1'b1;
            state_d         = ST_T0;
          end
          CLS_ST: begin
            ctrl_c.gra = 1'b1; ctrl_c.rout = 1'b1; ctrl_c.mdrin = 1'b1;
            state_d    = ST_T7;
          end
          default: begin
            ctrl_c.read = 1'b1; ctrl_c.mdrin = 1'b1;
            if (mem_done) state_d = ST_T7;
          end
        endcase
      end
      ST_T7: begin
        ctrl_c.mdrout = 1'b1;
        if (cls_c == CLS_ST) begin
          ctrl_c.write = 1'b1;
          if (mem_done) state_d = ST_T0;
        end else begin
          ctrl_c.gra = 1'b1; ctrl_c.rin = 1'b1;
          state_d    = ST_T0;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_T0;
    endcase
  end

  // Controls are forced low for as long as clear is held, not just from the next edge.
  assign ctrl_out_c = clear ? '0 : ctrl_c;

  assign Gra      = ctrl_out_c.gra;
  assign Grb      = ctrl_out_c.grb;
  assign Grc      = ctrl_out_c.grc;
  assign Rin      = ctrl_out_c.rin;
  assign Rout     = ctrl_out_c.rout;
  assign BAout    = ctrl_out_c.baout;
  assign PCout    = ctrl_out_c.pcout;
  assign PCin     = ctrl_out_c.pcin;
  assign IncPC    = ctrl_out_c.incpc;
  assign MARin    = ctrl_out_c.marin;
  assign MDRin    = ctrl_out_c.mdrin;
  assign MDRout   = ctrl_out_c.mdrout;
  assign Read     = ctrl_out_c.read;
  assign Write    = ctrl_out_c.write;
  assign IRin     = ctrl_out_c.irin;
  assign Yin      = ctrl_out_c.yin;
  assign Zin      = ctrl_out_c.zin;
  assign Zlowout  = ctrl_out_c.zlowout;
  assign Zhighout = ctrl_out_c.zhighout;
  assign HIin     = ctrl_out_c.hiin;
  assign LOin     = ctrl_out_c.loin;
  assign HIout    = ctrl_out_c.hiout;
  assign LOout    = ctrl_out_c.loout;
  assign Cout     = ctrl_out_c.cout;
  assign alu_op   = ctrl_out_c.alu_op;
  assign illegal  = ctrl_out_c.illegal;
  assign run      = (state_q != ST_HALT);

`ifdef CTRL_INSTR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Every return to T0 marks a retired instruction; HALT never returns.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == ST_T0 && state_q != ST_T0) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected control words queued by the driver, checked by a monitor.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] ir;
  logic        mem_ready;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout;
  logic Read, Write, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin, HIout, LOout, Cout;
  logic [4:0]  alu_op;
  logic        run, illegal;
`ifdef CTRL_INSTR_CNT_EN
  logic [31:0] instr_count;
`endif

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .HIout(HIout),
    .LOout(LOout), .Cout(Cout), .alu_op(alu_op), .run(run), .illegal(illegal)
`ifdef CTRL_INSTR_CNT_EN
    , .instr_count(instr_count)
`endif
  );

  always #5 clock = ~clock;

  localparam logic [31:0] M_GRA = 32'h1 << 0,  M_GRB = 32'h1 << 1,  M_GRC = 32'h1 << 2;
  localparam logic [31:0] M_RIN = 32'h1 << 3,  M_ROUT = 32'h1 << 4, M_BAOUT = 32'h1 << 5;
  localparam logic [31:0] M_PCOUT = 32'h1 << 6, M_PCIN = 32'h1 << 7, M_INCPC = 32'h1 << 8;
  localparam logic [31:0] M_MARIN = 32'h1 << 9, M_MDRIN = 32'h1 << 10, M_MDROUT = 32'h1 << 11;
  localparam logic [31:0] M_READ = 32'h1 << 12, M_WRITE = 32'h1 << 13, M_IRIN = 32'h1 << 14;
  localparam logic [31:0] M_YIN = 32'h1 << 15, M_ZIN = 32'h1 << 16, M_ZLOW = 32'h1 << 17;
  localparam logic [31:0] M_ZHIGH = 32'h1 << 18, M_HIIN = 32'h1 << 19, M_LOIN = 32'h1 << 20;
  localparam logic [31:0] M_HIOUT = 32'h1 << 21, M_LOOUT = 32'h1 << 22, M_COUT = 32'h1 << 23;
  localparam logic [31:0] M_RUN = 32'h1 << 29, M_ILL = 32'h1 << 30;

  localparam logic [31:0] E_T0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [31:0] E_T1 = M_RUN | M_ZLOW | M_PCIN | M_READ | M_MDRIN;
  localparam logic [31:0] E_T2 = M_RUN | M_MDROUT | M_IRIN;

  function automatic logic [31:0] alu(input logic [4:0] op);
    return {3'b000, op, 24'h0};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ir_next;
  logic [31:0] obs;
  int          checks   = 0;
  int          failures = 0;

  assign obs = {1'b0, illegal, run, alu_op, Cout, LOout, HIout, LOin, HIin, Zhighout,
                Zlowout, Zin, Yin, IRin, Write, Read, MDRout, MDRin, MARin, IncPC,
                PCin, PCout, BAout, Rout, Rin, Grc, Grb, Gra};

  // Monitor: every cycle that has a queued expectation is compared mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.val) begin
        failures++;
        $display("FAIL %s: got=%h expected=%h (t=%0t)", e.name, obs, e.val, $time);
      end
    end
  end

  task automatic cyc(input logic clr, input logic rdy, input logic [31:0] e, input string nm);
    @(posedge clock);
    #1;
    clear     = clr;
    mem_ready = rdy;
    ir        = ir_next;
    exp_q.push_back('{nm, e});
  endtask

  task automatic fetch(input string nm, input logic [31:0] instr, input int stall);
    ir_next = instr;
    cyc(1'b0, 1'b1, E_T0, {nm, ".T0"});
    for (int i = 0; i < stall; i++) cyc(1'b0, 1'b0, E_T1, {nm, ".T1wait"});
    cyc(1'b0, 1'b1, E_T1, {nm, ".T1"});
    cyc(1'b0, 1'b1, E_T2, {nm, ".T2"});
  endtask

  initial begin
    clear     = 1'b1;
    mem_ready = 1'b0;
    ir        = 32'h1988_8000;
    ir_next   = 32'h1988_8000;

    cyc(1'b1, 1'b0, M_RUN, "reset0");
    cyc(1'b1, 1'b1, M_RUN, "reset1");

    // add r3,r1,r2
    fetch("add", 32'h1988_8000, 0);
    cyc(1'b0, 1'b1, M_RUN | M_GRB | M_ROUT | M_YIN, "add.T3");
    cyc(1'b0, 1'b1, M_RUN | M_GRC | M_ROUT | M_ZIN | alu(5'b00011), "add.T4");
    cyc(1'b0, 1'b1, M_RUN | M_ZLOW | M_GRA | M_RIN, "add.T5");

    // ld r2,0x45(r1) with three-cycle memory latency in both memory states
    fetch("ld", 32'h0108_0045, 3);
    cyc(1'b0, 1'b1, M_RUN | M_GRB | M_BAOUT | M_YIN, "ld.T3");
    cyc(1'b0, 1'b1, M_RUN | M_COUT | M_ZIN | alu(5'b00011), "ld.T4");
    cyc(1'b0, 1'b1, M_RUN | M_ZLOW | M_MARIN, "ld.T5");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, M_RUN | M_READ | M_MDRIN, "ld.T6wait");
    cyc(1'b0, 1'b1, M_RUN | M_READ | M_MDRIN, "ld.T6");
    cyc(1'b0, 1'b0, M_RUN | M_MDROUT | M_GRA | M_RIN, "ld.T7");

    // st 0x90(r3),r4: T6 must not wait on mem_ready, T7 stalls for two cycles
    fetch("st", 32'h1218_0090, 0);
    cyc(1'b0, 1'b1, M_RUN | M_GRB | M_BAOUT | M_YIN, "st.T3");
    cyc(1'b0, 1'b1, M_RUN | M_COUT | M_ZIN | alu(5'b00011), "st.T4");
    cyc(1'b0, 1'b1, M_RUN | M_ZLOW | M_MARIN, "st.T5");
    cyc(1'b0, 1'b0, M_RUN | M_GRA | M_ROUT | M_MDRIN, "st.T6");
    cyc(1'b0, 1'b0, M_RUN | M_MDROUT | M_WRITE, "st.T7wait");
    cyc(1'b0, 1'b0, M_RUN | M_MDROUT | M_WRITE, "st.T7wait");
    cyc(1'b0, 1'b1, M_RUN | M_MDROUT | M_WRITE, "st.T7");

    // mul r3,r1
    fetch("mul", 32'h8188_0000, 0);
    cyc(1'b0, 1'b1, M_RUN | M_GRA | M_ROUT | M_YIN, "mul.T3");
    cyc(1'b0, 1'b1, M_RUN | M_GRB | M_ROUT | M_ZIN | alu(5'b10000), "mul.T4");
    cyc(1'b0, 1'b1, M_RUN | M_ZLOW | M_LOIN, "mul.T5");
    cyc(1'b0, 1'b1, M_RUN | M_ZHIGH | M_HIIN, "mul.T6");

    // ori: immediate form maps to the OR code
    fetch("ori", 32'h7000_0000, 0);
    cyc(1'b0, 1'b1, M_RUN | M_GRB | M_ROUT | M_YIN, "ori.T3");
    cyc(1'b0, 1'b1, M_RUN | M_COUT | M_ZIN | alu(5'b00110), "ori.T4");
    cyc(1'b0, 1'b1, M_RUN | M_ZLOW | M_GRA | M_RIN, "ori.T5");

    // neg
    fetch("neg", 32'h8800_0000, 0);
    cyc(1'b0, 1'b1, M_RUN | M_GRB | M_ROUT | M_ZIN | alu(5'b10001), "neg.T3");
    cyc(1'b0, 1'b1, M_RUN | M_ZLOW | M_GRA | M_RIN, "neg.T4");

    // mfhi then mflo
    fetch("mfhi", 32'hC000_0000, 0);
    cyc(1'b0, 1'b1, M_RUN | M_HIOUT | M_GRA | M_RIN, "mfhi.T3");
    fetch("mflo", 32'hC800_0000, 0);
    cyc(1'b0, 1'b1, M_RUN | M_LOOUT | M_GRA | M_RIN, "mflo.T3");

    // ldi
    fetch("ldi", 32'h0800_0000, 0);
    cyc(1'b0, 1'b1, M_RUN | M_GRB | M_BAOUT | M_YIN, "ldi.T3");
    cyc(1'b0, 1'b1, M_RUN | M_COUT | M_ZIN | alu(5'b00011), "ldi.T4");
    cyc(1'b0, 1'b1, M_RUN | M_ZLOW | M_GRA | M_RIN, "ldi.T5");

    // nop, then unsupported opcode 10100
    fetch("nop", 32'hD000_0000, 0);
    cyc(1'b0, 1'b1, M_RUN, "nop.T3");
    fetch("ill", 32'hA000_0000, 0);
    cyc(1'b0, 1'b1, M_RUN | M_ILL, "ill.T3");

    // clear in the middle of an ld data stall
    fetch("ldc", 32'h0108_0045, 0);
    cyc(1'b0, 1'b1, M_RUN | M_GRB | M_BAOUT | M_YIN, "ldc.T3");
    cyc(1'b0, 1'b1, M_RUN | M_COUT | M_ZIN | alu(5'b00011), "ldc.T4");
    cyc(1'b0, 1'b0, M_RUN | M_ZLOW | M_MARIN, "ldc.T5");
    cyc(1'b0, 1'b0, M_RUN | M_READ | M_MDRIN, "ldc.T6wait");
    cyc(1'b1, 1'b0, M_RUN, "ldc.clear");
    ir_next = 32'hD000_0000;
    cyc(1'b0, 1'b0, E_T0, "restart.T0");
    cyc(1'b0, 1'b1, E_T1, "restart.T1");
    cyc(1'b0, 1'b1, E_T2, "restart.T2");
    cyc(1'b0, 1'b1, M_RUN, "restart.T3");

    // halt: outputs and run stay low until clear
    fetch("halt", 32'hD800_0000, 0);
    cyc(1'b0, 1'b1, M_RUN, "halt.T3");
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'(i % 2), 32'h0, "halt.idle");
    cyc(1'b1, 1'b0, M_RUN, "halt.clear");
    fetch("add2", 32'h1988_8000, 1);
    cyc(1'b0, 1'b1, M_RUN | M_GRB | M_ROUT | M_YIN, "add2.T3");
    cyc(1'b0, 1'b1, M_RUN | M_GRC | M_ROUT | M_ZIN | alu(5'b00011), "add2.T4");
    cyc(1'b0, 1'b1, M_RUN | M_ZLOW | M_GRA | M_RIN, "add2.T5");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
